// File: rtl/hp_pack.sv
// hp_pack -- half-precision round-and-pack unit.
//
// Packs a sign, an unbiased signed exponent and a 14-bit extended significand
// {hidden, frac[9:0], G, R, S} into an IEEE 754 binary16 word. Special-class
// flags take priority: nan > inf > zero > finite. The unit is a two-stage
// valid/ready pipeline. Stage 1 denormalizes tiny results. Stage 2 rounds,
// detects overflow and underflow, and packs the result.
//
// Optional feature: define HP_PACK_RMODE_EN to add the in_rm[1:0] port.
// The rounding modes are 0=RNE, 1=RTZ, 2=RDN and 3=RUP. Without the macro
// the unit always rounds to nearest, ties to even.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_sign, in_exp       result sign, signed unbiased exponent (EXP_W bits)
//   in_sig                {hidden, frac[9:0], G, R, S}
//                         value = in_sig / 2^13 * 2^in_exp
//   in_nan/inf/zero       special-class flags
//   in_rm                 rounding mode (only with HP_PACK_RMODE_EN)
//   out_valid / out_ready output handshake
//   out_f                 packed binary16 result
//   out_overflow          finite result exceeded the largest normal
//   out_underflow         result was tiny (before rounding) and inexact
//   out_inexact           rounding discarded nonzero bits
module hp_pack #(
    parameter int          EXP_W     = 8,
    parameter logic [15:0] CANON_NAN = 16'h7E00
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [13:0]             in_sig,
    input  logic                    in_nan,
    input  logic                    in_inf,
    input  logic                    in_zero,
`ifdef HP_PACK_RMODE_EN
    input  logic [1:0]              in_rm,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_f,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact
);

    typedef struct packed {
        logic [15:0] f;
        logic        of;
        logic        uf;
        logic        ix;
    } res_t;

    // Exponent math is done one bit wider than in_exp so extreme inputs cannot wrap.
    localparam logic signed [EXP_W:0] EMIN   = (EXP_W+1)'(-14);
    localparam logic signed [EXP_W:0] EMAX   = (EXP_W+1)'(15);
    localparam logic signed [EXP_W:0] SH_MAX = (EXP_W+1)'(14);

    // Round the stage-1 value and pack it as a finite result, or as overflow.
    function automatic res_t round_pack(input logic       sign,
                                        input logic [4:0]  be,
                                        input logic [13:0] sig,
                                        input logic        tiny,
                                        input logic        ovf,
                                        input logic [1:0]  rm);
        logic        g, r, s, lsb, ix, up, to_max;
        logic [11:0] m;
        logic [5:0]  e;
        logic [9:0]  frac;
        res_t        res;
        g   = sig[2];
        r   = sig[1];
        s   = sig[0];
        lsb = sig[3];
        ix  = g | r | s;
        case (rm)
            2'd1:    up = 1'b0;
            2'd2:    up = sign & ix;
            2'd3:    up = !sign & ix;
            default: up = g & (r | s | lsb);
        endcase
        m = {1'b0, sig[13:3]} + {11'd0, up};
        if (tiny) begin
            // A carry into the hidden position turns the subnormal into the minimum normal.
            e    = {5'd0, m[10]};
            frac = m[9:0];
        end else if (m[11]) begin
            e    = {1'b0, be} + 6'd1;
            frac = 10'd0;
        end else begin
            e    = {1'b0, be};
            frac = m[9:0];
        end
        // Directed modes that round toward zero saturate at the largest normal instead of infinity.
        to_max = (rm == 2'd1) || (rm == 2'd2 && !sign) || (rm == 2'd3 && sign);
        if (ovf || e >= 6'd31) begin
            res.f  = {sign, (to_max ? 15'h7BFF : 15'h7C00)};
            res.of = 1'b1;
            res.uf = 1'b0;
            res.ix = 1'b1;
        end else begin
            res.f  = {sign, e[4:0], frac};
            res.of = 1'b0;
            res.uf = tiny & ix;
            res.ix = ix;
        end
        return res;
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic signed [EXP_W:0] exp_x, sh_full;
    logic [3:0]            sh;
    logic [27:0]           wide;
    logic                  tiny_c, ovf_c;
    logic [4:0]            be_c;
    logic [13:0]           sig_c;

    always_comb begin
        exp_x   = {in_exp[EXP_W-1], in_exp};
        tiny_c  = exp_x < EMIN;
        ovf_c   = exp_x > EMAX;
        sh_full = EMIN - exp_x;
        sh      = 4'd0;
        if (tiny_c)
            sh = (sh_full > SH_MAX) ? 4'd14 : sh_full[3:0];
        // Zeros are appended below the operand so every shifted-out bit can be folded into S.
        wide  = {in_sig, 14'd0} >> sh;
        sig_c = {wide[27:15], wide[14] | (|wide[13:0])};
        // Only the low 5 bits matter: the in-range exponents -14..15 give be = 1..30.
        be_c  = tiny_c ? 5'd0 : in_exp[4:0] + 5'd15;
    end

    // ---- stage 1: denormalize ----
    logic        vld_p1;
    logic        sign_p1, tiny_p1, ovf_p1, nan_p1, inf_p1, zero_p1;
    logic [4:0]  be_p1;
    logic [13:0] sig_p1;
    logic [1:0]  rm_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (en)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            sign_p1 <= in_sign;
            tiny_p1 <= tiny_c;
            ovf_p1  <= ovf_c;
            be_p1   <= be_c;
            sig_p1  <= sig_c;
            nan_p1  <= in_nan;
            inf_p1  <= in_inf;
            zero_p1 <= in_zero;
        end
    end

`ifdef HP_PACK_RMODE_EN
    always_ff @(posedge clk) begin
        if (en && in_valid)
            rm_p1 <= in_rm;
    end
`else
    assign rm_p1 = 2'd0;
`endif

    // ---- stage 2: round, apply specials, pack ----
    res_t res_c;

    always_comb begin
        res_c = round_pack(sign_p1, be_p1, sig_p1, tiny_p1, ovf_p1, rm_p1);
        if (nan_p1) begin
            res_c = '{f: CANON_NAN, of: 1'b0, uf: 1'b0, ix: 1'b0};
        end else if (inf_p1) begin
            res_c = '{f: {sign_p1, 15'h7C00}, of: 1'b0, uf: 1'b0, ix: 1'b0};
        end else if (zero_p1) begin
            res_c = '{f: {sign_p1, 15'h0000}, of: 1'b0, uf: 1'b0, ix: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_f         <= 16'h0000;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (en) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_f         <= res_c.f;
                out_overflow  <= res_c.of;
                out_underflow <= res_c.uf;
                out_inexact   <= res_c.ix;
            end
        end
    end

endmodule

// File: doc/hp_pack.md
Name: hp_pack

Overview:
- Half-precision round-and-pack unit: the inverse of the half-precision classifier/unpacker.
- Takes a sign, an unbiased signed exponent, an extended significand with guard/round/sticky bits, and special-class flags.
- Produces an IEEE 754 binary16 word with exception flags.
- Sits at the back end of every FPU datapath (add/mul/convert) as a 2-stage valid/ready pipeline.

Parameters:
- EXP_W, 8: width of signed unbiased input exponent (two's complement).
- CANON_NAN, 16'h7E00: encoding emitted for any NaN result.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operand valid
- in_ready  output  1  unit accepts input this cycle
- in_sign  input  1  result sign
- in_exp  input  EXP_W  signed unbiased exponent
- in_sig  input  14  {hidden[13], frac[12:3], G[2], R[1], S[0]}; value = in_sig/2^13 * 2^in_exp
- in_nan  input  1  result is NaN
- in_inf  input  1  result is infinity
- in_zero  input  1  result is zero
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_f  output  16  packed binary16 result
- out_overflow  output  1  finite result exceeded max normal
- out_underflow  output  1  tiny and inexact
- out_inexact  output  1  rounding discarded nonzero bits

Behaviour:
- Reset: out_valid=0, out_f=16'h0000, all flags 0, both stage valids 0. in_ready is combinational and is 1 after reset.
- Pipeline enable: en = !out_valid | out_ready. in_ready = en. Both stages advance only when en=1; transfer occurs when in_valid & in_ready.
- Latency: an accepted input appears on out_f two cycles later if unstalled. Results are in order, with no drops or duplicates. Bubbles propagate and are not collapsed.
- While out_valid & !out_ready: out_f and flags are held stable.
- Special priority: nan > inf > zero > finite.
  - nan: out_f=CANON_NAN; flags 0.
  - inf: {sign,15'h7C00}.
  - zero: {sign,15'h0}.
- Finite inputs require in_sig[13]=1 (normalized); otherwise behaviour is undefined and not verified.
- Stage 1 (denormalize):
  - If in_exp < -14, right-shift in_sig by sh = -14 - in_exp, saturated at 14.
  - Shifted-out bits are ORed into S. Set tiny=1.
  - Biased exponent be = in_exp + 15; forced to 0 when tiny.
  - If in_exp > 15: force overflow path.
- Stage 2 (round RNE):
  - lsb = frac[0]; up = G & (R | S | lsb).
  - inexact = G | R | S.
  - On mantissa carry:
    - Normal: be+1, frac=0.
    - Subnormal: becomes be=1 (min normal).
  - If be >= 31 after rounding: out_f = {sign,15'h7C00}; overflow=1; inexact=1.
  - underflow = tiny & inexact. Evaluated before rounding, so tininess is detected before rounding.
  - Result that rounds to 0 from tiny: {sign,15'h0} with underflow=1, inexact=1.
- Exponent arithmetic uses EXP_W+1 bits internally, so no wrap-around. Both in_exp = -2^(EXP_W-1) and in_exp = 2^(EXP_W-1)-1 are handled without wrap.
- Reset mid-operation: both stages cleared immediately; in-flight data discarded; no result emitted after rst_n rises.

Optional Feature:
- Macro: HP_PACK_RMODE_EN.
- Defined: adds input port in_rm[1:0], sampled with the operand. Modes:
  - 0 = RNE
  - 1 = RTZ: up=0
  - 2 = RDN: up = sign & (G|R|S)
  - 3 = RUP: up = !sign & (G|R|S)
- Overflow under RTZ, under RDN with sign=0, and under RUP with sign=1 yields {sign,15'h7BFF} with overflow=1, inexact=1.
- Undefined: no in_rm port; RNE only.

Test Plan:
- Round-to-nearest-even cases, each returned 2 cycles after acceptance:
  - sign=0, exp=0, sig=14'h2000 -> out_f=16'h3C00, all flags 0.
  - sig=14'h2004 -> 16'h3C00, inexact=1.
  - sig=14'h200C -> 16'h3C02, inexact=1.
- Overflow: exp=15, sig=14'h3FFC -> rounds up -> 16'h7C00, overflow=1, inexact=1. Same input with exp=40 -> 16'h7C00, overflow=1.
- Subnormal/underflow:
  - exp=-24, sig=14'h2000 -> 16'h0001, no flags.
  - exp=-25, sig=14'h2000 -> 16'h0000, underflow=1, inexact=1.
  - exp=-15, sig=14'h3FFF -> 16'h0400, underflow=1, inexact=1.
- Specials:
  - in_nan=1 (any sign) -> 16'h7E00.
  - in_inf=1, sign=1 -> 16'hFC00.
  - in_zero=1, sign=1 -> 16'h8000.
  - in_nan & in_inf both set -> 16'h7E00.
- Backpressure: issue 4 back-to-back inputs with out_ready=0.
  - in_ready drops once out_valid=1.
  - out_f holds its first value for 5 cycles.
  - Raising out_ready drains all 4 results in order, one per cycle.
- Reset: drop rst_n with 2 operands in flight -> out_valid=0 and out_f=16'h0000 immediately; after release, no stale result appears and in_ready=1.
